// File: rtl/nto1_snn_layer_if.sv
// Control, weight-load and observation signals of the N_IN-to-1 spiking layer.
// The layer itself connects through the slave modport; the driver uses master.
interface nto1_snn_layer_if #(
    parameter int N_IN = 8,
    parameter int W_DW = 16,
    parameter int V_DW = 24
);
    localparam int AW = (N_IN > 1) ? $clog2(N_IN) : 1;

    logic                   en;
    logic                   w_wr_en;
    logic [AW-1:0]          w_wr_addr;
    logic signed [W_DW-1:0] w_wr_data;
    logic [N_IN-1:0]        in_spikes;
    logic                   learn_en;
    logic                   out_spike;
    logic                   busy;
    logic signed [V_DW-1:0] v_mem;
    logic [15:0]            spike_cnt;

    modport master (
        output en, w_wr_en, w_wr_addr, w_wr_data, in_spikes, learn_en,
        input  out_spike, busy, v_mem, spike_cnt
    );

    modport slave (
        input  en, w_wr_en, w_wr_addr, w_wr_data, in_spikes, learn_en,
        output out_spike, busy, v_mem, spike_cnt
    );
endinterface

// File: rtl/nto1_snn_layer.sv
// N_IN-to-1 leaky integrate-and-fire layer with presynaptic traces and a
// sequential trace-driven weight update that runs after each output spike.
module nto1_snn_layer #(
    parameter int          N_IN       = 8,
    parameter int          W_DW       = 16,
    parameter int          FRAC       = 12,
    parameter int          V_DW       = 24,
    parameter int          V_TH       = 16384,
    parameter int          V_RESET    = 0,
    parameter int          LEAK_SHIFT = 4,
    parameter int          REFRAC     = 4,
    parameter int          TR_DW      = 8,
    parameter int          TR_SHIFT   = 3,
    parameter logic [15:0] LR         = 16'h0148,
    parameter int          DEP        = 8,
    parameter int          WMAX       = 4096
) (
    input logic             clk,
    input logic             rst,
    nto1_snn_layer_if.slave snn
);
    localparam int AW = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int SW = W_DW + $clog2(N_IN);
    localparam int XW = V_DW + 2;
    localparam int UW = W_DW + 2;
    localparam int PW = TR_DW + 16;
    localparam int RW = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;

    localparam logic signed [V_DW-1:0] V_TH_S    = V_DW'(V_TH);
    localparam logic signed [V_DW-1:0] V_RESET_S = V_DW'(V_RESET);
    localparam logic signed [V_DW-1:0] V_MAX_V   = {1'b0, {(V_DW-1){1'b1}}};
    localparam logic signed [V_DW-1:0] V_MIN_V   = ~V_MAX_V;
    localparam logic signed [XW-1:0]   V_MAX_X   = XW'(V_MAX_V);
    localparam logic signed [XW-1:0]   V_MIN_X   = ~V_MAX_X;
    localparam logic signed [UW-1:0]   WMAX_U    = UW'(WMAX);
    localparam logic signed [UW-1:0]   DEP_U     = UW'(DEP);
    localparam logic [TR_DW-1:0]       TR_MAX    = {TR_DW{1'b1}};
    localparam logic [RW-1:0]          REFRAC_R  = RW'(REFRAC);
    localparam logic [AW:0]            N_IN_A    = (AW+1)'(N_IN);
    localparam logic [AW-1:0]          LAST_IDX  = AW'(N_IN - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_UPDATE
    } state_t;

    state_t                 r_state;
    logic signed [W_DW-1:0] r_w [N_IN];
    logic [TR_DW-1:0]       r_tr [N_IN];
    logic signed [V_DW-1:0] r_v;
    logic [RW-1:0]          r_refrac;
    logic [15:0]            r_cnt;
    logic                   r_spike;
    logic                   r_busy;
    logic [AW-1:0]          r_idx;

    logic signed [SW-1:0]   w_isum;
    logic signed [V_DW-1:0] w_leak;
    logic signed [XW-1:0]   w_v_wide;
    logic signed [V_DW-1:0] w_v_next;
    logic                   w_fire;
    logic [TR_DW-1:0]       w_tr_next [N_IN];
    logic [TR_DW-1:0]       w_tr_sel;
    logic [PW-1:0]          w_prod;
    logic [UW-1:0]          w_dw;
    logic signed [UW-1:0]   w_w_upd;
    logic signed [W_DW-1:0] w_w_clamp;

    // NOTE: the accumulator is a temporary inside one always_comb, so blocking
    // assignments give the running sum; it starts from a default so no latch forms.
    always_comb begin
        w_isum = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (snn.in_spikes[i]) begin
                w_isum = w_isum + {{(SW-W_DW){r_w[i][W_DW-1]}}, r_w[i]};
            end
        end
    end

    assign w_leak   = r_v >>> LEAK_SHIFT;
    assign w_v_wide = {{2{r_v[V_DW-1]}}, r_v}
                    - {{2{w_leak[V_DW-1]}}, w_leak}
                    + {{(XW-SW){w_isum[SW-1]}}, w_isum};

    always_comb begin
        if (w_v_wide > V_MAX_X) begin
            w_v_next = V_MAX_V;
        end else if (w_v_wide < V_MIN_X) begin
            w_v_next = V_MIN_V;
        end else begin
            w_v_next = w_v_wide[V_DW-1:0];
        end
    end

    assign w_fire = (r_refrac == '0) && (w_v_next >= V_TH_S);

    // A fresh spike loads the max; otherwise decay, forcing a unit step at the tail.
    always_comb begin
        for (int i = 0; i < N_IN; i++) begin
            if (snn.in_spikes[i]) begin
                w_tr_next[i] = TR_MAX;
            end else if ((r_tr[i] >> TR_SHIFT) != '0) begin
                w_tr_next[i] = r_tr[i] - (r_tr[i] >> TR_SHIFT);
            end else if (r_tr[i] != '0) begin
                w_tr_next[i] = r_tr[i] - TR_DW'(1);
            end else begin
                w_tr_next[i] = '0;
            end
        end
    end

    assign w_tr_sel = r_tr[r_idx];
    assign w_prod   = PW'(w_tr_sel) * PW'(LR);
    assign w_dw     = UW'(w_prod >> FRAC);
    assign w_w_upd  = {{2{r_w[r_idx][W_DW-1]}}, r_w[r_idx]} + w_dw - DEP_U;

    always_comb begin
        if (w_w_upd[UW-1]) begin
            w_w_clamp = '0;
        end else if (w_w_upd > WMAX_U) begin
            w_w_clamp = W_DW'(WMAX);
        end else begin
            w_w_clamp = w_w_upd[W_DW-1:0];
        end
    end

    // NOTE: weights are state the reset must clear, so the array sits inside
    // the reset branch rather than being left as an unreset memory.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= ST_IDLE;
            r_v      <= '0;
            r_refrac <= '0;
            r_cnt    <= '0;
            r_spike  <= 1'b0;
            r_busy   <= 1'b0;
            r_idx    <= '0;
            for (int i = 0; i < N_IN; i++) begin
                r_w[i]  <= '0;
                r_tr[i] <= '0;
            end
        end else begin
            r_spike <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_v      <= '0;
                    r_refrac <= '0;
                    r_cnt    <= '0;
                    r_busy   <= 1'b0;
                    r_idx    <= '0;
                    for (int i = 0; i < N_IN; i++) begin
                        r_tr[i] <= '0;
                    end
                    if (snn.w_wr_en && ({1'b0, snn.w_wr_addr} < N_IN_A)) begin
                        r_w[snn.w_wr_addr] <= snn.w_wr_data;
                    end
                    if (snn.en) begin
                        r_state <= ST_RUN;
                    end
                end

                ST_RUN: begin
                    if (!snn.en) begin
                        r_state  <= ST_IDLE;
                        r_v      <= '0;
                        r_refrac <= '0;
                        r_cnt    <= '0;
                        for (int i = 0; i < N_IN; i++) begin
                            r_tr[i] <= '0;
                        end
                    end else begin
                        for (int i = 0; i < N_IN; i++) begin
                            r_tr[i] <= w_tr_next[i];
                        end
                        if (r_refrac != '0) begin
                            r_v      <= V_RESET_S;
                            r_refrac <= r_refrac - RW'(1);
                        end else if (w_fire) begin
                            r_v      <= V_RESET_S;
                            r_refrac <= REFRAC_R;
                            r_spike  <= 1'b1;
                            r_cnt    <= r_cnt + 16'd1;
                            if (snn.learn_en) begin
                                r_state <= ST_UPDATE;
                                r_busy  <= 1'b1;
                                r_idx   <= '0;
                            end
                        end else begin
                            r_v <= w_v_next;
                        end
                    end
                end

                ST_UPDATE: begin
                    // Leaving early keeps whatever weights were already rewritten.
                    if (!snn.en) begin
                        r_state  <= ST_IDLE;
                        r_busy   <= 1'b0;
                        r_idx    <= '0;
                        r_v      <= '0;
                        r_refrac <= '0;
                        r_cnt    <= '0;
                        for (int i = 0; i < N_IN; i++) begin
                            r_tr[i] <= '0;
                        end
                    end else begin
                        r_w[r_idx] <= w_w_clamp;
                        if (r_idx == LAST_IDX) begin
                            r_state <= ST_RUN;
                            r_busy  <= 1'b0;
                            r_idx   <= '0;
                        end else begin
                            r_idx <= r_idx + AW'(1);
                        end
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign snn.out_spike = r_spike;
    assign snn.busy      = r_busy;
    assign snn.v_mem     = r_v;
    assign snn.spike_cnt = r_cnt;
endmodule

// File: tb/tb_nto1_snn_layer.sv
// Directed bench for nto1_snn_layer: stimulus pushes expected per-cycle outputs
// into a scoreboard queue; a negedge monitor pops and compares them.
module tb_nto1_snn_layer;
    localparam int N  = 6;
    localparam int AW = 3;

    localparam logic [3:0] M_V   = 4'b0001;
    localparam logic [3:0] M_S   = 4'b0010;
    localparam logic [3:0] M_B   = 4'b0100;
    localparam logic [3:0] M_C   = 4'b1000;
    localparam logic [3:0] M_ALL = 4'b1111;

    typedef struct {
        int                 cyc;
        string              name;
        logic signed [23:0] v;
        logic               spk;
        logic               bsy;
        logic [15:0]        cnt;
        logic [3:0]         m;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;
    exp_t sb [$];
    exp_t mon_e;

    always #5 clk = ~clk;

    nto1_snn_layer_if #(.N_IN(N)) snn ();

    nto1_snn_layer #(.N_IN(N)) dut (
        .clk (clk),
        .rst (rst),
        .snn (snn)
    );

    always @(posedge clk) cyc <= cyc + 1;

    task automatic cmp(string nm, string fld, longint act, longint want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL %s %s: actual=%0d expected=%0d (cycle %0d)", nm, fld, act, want, cyc);
        end
    endtask

    always @(negedge clk) begin
        while (sb.size() != 0 && sb[0].cyc <= cyc) begin
            mon_e = sb.pop_front();
            if (mon_e.cyc != cyc) begin
                cmp(mon_e.name, "check_cycle", longint'(cyc), longint'(mon_e.cyc));
            end else begin
                if (mon_e.m[0]) cmp(mon_e.name, "v_mem", longint'(snn.v_mem), longint'(mon_e.v));
                if (mon_e.m[1]) cmp(mon_e.name, "out_spike", longint'(snn.out_spike), longint'(mon_e.spk));
                if (mon_e.m[2]) cmp(mon_e.name, "busy", longint'(snn.busy), longint'(mon_e.bsy));
                if (mon_e.m[3]) cmp(mon_e.name, "spike_cnt", longint'(snn.spike_cnt), longint'(mon_e.cnt));
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_nxt(string nm, int v, logic s, logic b, int c, logic [3:0] m);
        exp_t e;
        e.cyc  = cyc + 1;
        e.name = nm;
        e.v    = 24'(v);
        e.spk  = s;
        e.bsy  = b;
        e.cnt  = 16'(c);
        e.m    = m;
        sb.push_back(e);
    endtask

    task automatic drive(logic e, logic l, logic [N-1:0] sp);
        snn.en        = e;
        snn.learn_en  = l;
        snn.in_spikes = sp;
    endtask

    task automatic write_w(int a, int d);
        snn.en        = 1'b0;
        snn.w_wr_en   = 1'b1;
        snn.w_wr_addr = AW'(a);
        snn.w_wr_data = 16'(d);
        tick();
        snn.w_wr_en   = 1'b0;
    endtask

    // One RUN edge with only input idx active: v_mem = w[idx] from a zero membrane.
    task automatic read_w(int idx, int want, string nm);
        logic [N-1:0] sp;
        sp      = '0;
        sp[idx] = 1'b1;
        drive(1'b1, 1'b0, sp);
        tick();
        expect_nxt(nm, want, 1'b0, 1'b0, 0, M_ALL);
        tick();
        drive(1'b0, 1'b0, '0);
        expect_nxt({nm, "_idle"}, 0, 1'b0, 1'b0, 0, M_ALL);
        tick();
    endtask

    task automatic fire_2000(string nm, logic learn);
        int vs [4];
        vs = '{4000, 7750, 11266, 14562};
        drive(1'b1, learn, 6'b000011);
        tick();
        for (int k = 0; k < 4; k++) begin
            expect_nxt(nm, vs[k], 1'b0, 1'b0, 0, M_ALL);
            tick();
        end
        expect_nxt({nm, "_fire"}, 0, 1'b1, learn, 1, M_ALL);
        tick();
    endtask

    task automatic update_edges(string nm, int n);
        for (int k = 0; k < n; k++) begin
            expect_nxt(nm, 0, 1'b0, (k < N - 1), 1, M_ALL);
            tick();
        end
    endtask

    task automatic go_idle(string nm);
        drive(1'b0, 1'b0, '0);
        expect_nxt(nm, 0, 1'b0, 1'b0, 0, M_ALL);
        tick();
    endtask

    task automatic trace_probe(int gap, int want, string nm);
        write_w(0, 1000);
        write_w(1, 20000);
        drive(1'b1, 1'b1, 6'b000001);
        tick();
        expect_nxt({nm, "_pre"}, 1000, 1'b0, 1'b0, 0, M_ALL);
        tick();
        drive(1'b1, 1'b1, '0);
        for (int g = 0; g < gap; g++) begin
            expect_nxt({nm, "_gap"}, 0, 1'b0, 1'b0, 0, M_S | M_B | M_C);
            tick();
        end
        drive(1'b1, 1'b1, 6'b000010);
        expect_nxt({nm, "_fire"}, 0, 1'b1, 1'b1, 1, M_ALL);
        tick();
        drive(1'b1, 1'b1, '0);
        update_edges({nm, "_upd"}, N);
        go_idle({nm, "_idle"});
        read_w(0, want, {nm, "_w0"});
    endtask

    initial begin
        int vs [4];
        vs = '{4000, 7750, 11266, 14562};

        rst           = 1'b0;
        snn.en        = 1'b0;
        snn.learn_en  = 1'b0;
        snn.in_spikes = '0;
        snn.w_wr_en   = 1'b0;
        snn.w_wr_addr = '0;
        snn.w_wr_data = '0;
        tick();
        tick();
        expect_nxt("reset", 0, 1'b0, 1'b0, 0, M_ALL);
        tick();
        rst = 1'b1;

        // Integrate, fire, refractory, fire again without learning.
        write_w(0, 2000);
        write_w(1, 2000);
        fire_2000("nolearn", 1'b0);
        for (int k = 0; k < 4; k++) begin
            expect_nxt("refrac", 0, 1'b0, 1'b0, 1, M_ALL);
            tick();
        end
        for (int k = 0; k < 4; k++) begin
            expect_nxt("second_rise", vs[k], 1'b0, 1'b0, 1, M_ALL);
            tick();
        end
        expect_nxt("second_fire", 0, 1'b1, 1'b0, 2, M_ALL);
        tick();
        go_idle("nolearn_idle");

        // Learning: both traces at max, weights 2000 -> 2012.
        fire_2000("learn", 1'b1);
        update_edges("learn_upd", N);
        for (int k = 0; k < 4; k++) begin
            expect_nxt("learn_refrac", 0, 1'b0, 1'b0, 1, M_ALL);
            tick();
        end
        expect_nxt("learn_w_sum", 4024, 1'b0, 1'b0, 1, M_ALL);
        tick();
        expect_nxt("learn_leak", 7797, 1'b0, 1'b0, 1, M_ALL);
        tick();
        go_idle("learn_idle");

        // Clamp: 4090+20-8 -> 4096, 4+0-8 -> 0.
        write_w(0, 4090);
        write_w(1, 4);
        drive(1'b1, 1'b1, 6'b000001);
        tick();
        vs = '{4090, 7925, 11520, 14890};
        for (int k = 0; k < 4; k++) begin
            expect_nxt("clamp_rise", vs[k], 1'b0, 1'b0, 0, M_ALL);
            tick();
        end
        expect_nxt("clamp_fire", 0, 1'b1, 1'b1, 1, M_ALL);
        tick();
        update_edges("clamp_upd", N);
        go_idle("clamp_idle");
        read_w(0, 4096, "clamp_hi");
        read_w(1, 0, "clamp_lo");

        // Writes during RUN and to an out-of-range address are dropped.
        write_w(0, 1234);
        write_w(2, 77);
        drive(1'b1, 1'b0, '0);
        tick();
        snn.w_wr_en   = 1'b1;
        snn.w_wr_addr = 3'd0;
        snn.w_wr_data = 16'sd999;
        expect_nxt("wr_run", 0, 1'b0, 1'b0, 0, M_ALL);
        tick();
        snn.w_wr_en = 1'b0;
        go_idle("wr_run_idle");
        write_w(N, 555);
        read_w(0, 1234, "wr_run_ignored");
        read_w(2, 77, "wr_oob_ignored");

        // Trace decay 224, 196, 172 and fully decayed, seen through dw.
        trace_probe(0, 1009, "tr224");
        trace_probe(1, 1007, "tr196");
        trace_probe(2, 1005, "tr172");
        trace_probe(60, 992, "tr0");

        // en=0 while index 3 is next: indices 0..2 updated, rest untouched.
        write_w(0, 2000);
        write_w(1, 2000);
        write_w(2, 100);
        write_w(3, 100);
        write_w(4, 100);
        write_w(5, 100);
        fire_2000("enq", 1'b1);
        update_edges("enq_upd", 3);
        go_idle("enq_abort");
        read_w(0, 2012, "enq_w0");
        read_w(2, 92, "enq_w2");
        read_w(3, 100, "enq_w3");
        read_w(5, 100, "enq_w5");

        // Reset at index 3 clears everything, weights included.
        write_w(0, 2000);
        write_w(1, 2000);
        fire_2000("rstq", 1'b1);
        update_edges("rstq_upd", 3);
        rst = 1'b0;
        expect_nxt("rstq_reset", 0, 1'b0, 1'b0, 0, M_ALL);
        tick();
        rst = 1'b1;
        drive(1'b0, 1'b0, '0);
        read_w(0, 0, "rst_w0");
        read_w(1, 0, "rst_w1");
        read_w(2, 0, "rst_w2");

        tick();
        tick();
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_drain: actual=%0d expected=0 pending entries", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/nto1_snn_layer.md
Name: nto1_snn_layer

Overview:
- Parametrised N_IN-to-1 spiking layer with on-chip learning.
- Holds N_IN synaptic weights and N_IN presynaptic traces, and integrates weighted input spikes into one leaky integrate-and-fire neuron with threshold, reset and refractory period.
- On each output spike, runs a sequential trace-driven weight update: potentiation weighted by LR, constant depression DEP, clamp to [0, WMAX].
- Sits between the AXI-stream spike/weight loader and the spike collector; it is the next-generation form of the fixed two-input test network.

Parameters:
N_IN, 8, number of input synapses (2..64)
W_DW, 16, signed weight width, Q format with FRAC fraction bits
FRAC, 12, fraction bits of weight and membrane (4096 = 1.0)
V_DW, 24, signed membrane width
V_TH, 16384, firing threshold (4.0)
V_RESET, 0, membrane value after spike and during refractory period
LEAK_SHIFT, 4, leak term = v >>> LEAK_SHIFT
REFRAC, 4, refractory cycles after a spike
TR_DW, 8, unsigned trace width; trace max = 2^TR_DW-1
TR_SHIFT, 3, trace decay shift
LR, 16'h0148, learning rate, unsigned, FRAC fraction bits
DEP, 8, constant depression per update (weight LSBs)
WMAX, 4096, upper weight clamp (1.0)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-low
en  in  1  1 = run, 0 = idle/configure
w_wr_en  in  1  weight write strobe (honoured in IDLE only)
w_wr_addr  in  clog2(N_IN)  weight index
w_wr_data  in  W_DW  signed weight value
in_spikes  in  N_IN  presynaptic spike vector, sampled every RUN cycle
learn_en  in  1  enables the weight update on output spike
out_spike  out  1  one-cycle output spike pulse
busy  out  1  high during UPDATE; in_spikes are ignored
v_mem  out  V_DW  current membrane potential
spike_cnt  out  16  output spikes since reset/IDLE, wraps at 2^16

Behaviour:
- Reset (rst=0 at posedge): state IDLE; all weights, traces, v_mem, refractory counter, spike_cnt, out_spike and busy are 0. Reset has priority over all other inputs in every state, including mid-UPDATE.
- States: IDLE, RUN, UPDATE.
  - IDLE→RUN when en=1.
  - RUN→IDLE when en=0.
  - RUN→UPDATE on the edge that fires, if learn_en=1.
  - UPDATE→RUN after index N_IN-1. If en=0 during UPDATE, go to IDLE; weights already updated are kept.
- IDLE:
  - w_wr_en=1 writes w[w_wr_addr] at the next edge.
  - Addresses >= N_IN are ignored.
  - Writes in RUN or UPDATE are ignored.
  - v_mem, traces, refractory counter and spike_cnt are held at 0.
- RUN, each edge:
  - I = sum of w[i] over set in_spikes[i], computed at width W_DW+clog2(N_IN), sign-extended to V_DW.
  - If refrac_cnt != 0: v stays V_RESET and refrac_cnt decrements.
  - Otherwise v_next = v - (v >>> LEAK_SHIFT) + I, saturated to the signed V_DW range.
  - If v_next >= V_TH: v <= V_RESET, refrac_cnt <= REFRAC, out_spike <= 1 for one cycle, spike_cnt increments. Otherwise v <= v_next.
  - Latency: in_spikes sampled at edge k appear in v_mem/out_spike after edge k (registered).
- Traces (RUN only, every edge, including refractory cycles):
  - in_spikes[i]=1 sets trace[i] to its max value.
  - Otherwise trace[i] <= trace[i] - (trace[i] >> TR_SHIFT).
  - If that shift is 0 and trace[i] != 0, subtract 1 instead so the trace reaches 0.
- UPDATE:
  - busy=1; processes one index per cycle, i = 0..N_IN-1.
  - Traces, v and refrac_cnt are frozen; refractory countdown resumes in RUN.
  - Traces used are the values written on the firing edge, so a presynaptic spike coincident with the output spike counts as max trace.
  - dw = (trace[i]*LR) >> FRAC, unsigned.
  - w_new = w[i] + dw - DEP, computed at W_DW+2 bits, then clamped to [0, WMAX].
  - busy falls on the edge that writes index N_IN-1.
- Output spike with learn_en=0: no UPDATE; busy stays 0.

Test Plan:
- N_IN=2, both weights written 2000 in IDLE, en=1, in_spikes=2'b11 constant, learn_en=0 → v_mem = 4000, 7750, 11266, 14562, then out_spike on the 5th RUN edge with v_mem=0; 4 refractory cycles at v=0; next spike 9 edges after the first; spike_cnt=2.
- Same setup, learn_en=1, all other weights = 0 → busy high for exactly N_IN cycles after the spike; both traces=255 so dw=(255*328)>>12=20; w becomes 2000+20-8=2012.
- Clamp: w[0]=4090 with trace 255 → 4096; w[1]=4 with trace 0 → 0 (floor).
- Writes: w_wr_en in RUN and addr=N_IN in IDLE → no weight changes, verified by a subsequent single-input spike giving I=stored value.
- Trace decay: one spike on input 0 then silence → 255, 224, 196, 172, … reaching 0 and staying 0.
- Reset: rst=0 mid-UPDATE at index 3, and en=0 mid-UPDATE → reset returns all weights/outputs to 0; en=0 goes to IDLE with indices 0..2 updated and the rest untouched.
